pwm_duty_meter: RTL and testbench

//  Closed-loop monitor for the PWM output stage. Samples a PWM waveform and measures high time and

---
 rtl/pwm_duty_meter_pkg.sv | 21 ++
 rtl/pwm_div_restoring.sv | 70 +++++++
 rtl/pwm_duty_meter.sv | 165 ++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants for the PWM duty meter: duty encoding, FSM state codes
// and the divider width derivation.
package pwm_duty_meter_pkg;

  // Duty is an integer percentage, same encoding as the generator's duty input.
  localparam int DUTY_MAX = 100;
  localparam int DUTY_W   = 8;

  // Extra numerator bits needed to hold high*100 (100 < 2^7).
  localparam int SCALE_W  = 7;

  // Measurement FSM state codes.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Width of the scaled numerator, which is also the divider iteration count.
  function automatic int div_w(input int cnt_w);
    return cnt_w + SCALE_W;
  endfunction

endpackage

// File: rtl/pwm_div_restoring.sv
// Serial restoring divider: one quotient bit per cycle, N_W cycles per divide.
// The quotient is shifted into the numerator register as numerator bits leave it.
module pwm_div_restoring #(
  parameter int N_W = 31,
  parameter int D_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quo
);

  localparam int CNT_BITS = $clog2(N_W + 1);

  logic [N_W-1:0]      acc_reg;
  logic [D_W-1:0]      rem_reg;
  logic [D_W-1:0]      den_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic                busy_reg;

  logic [D_W:0]   rem_shift;
  logic [D_W:0]   diff;
  logic           ge;
  logic [D_W-1:0] rem_next;
  logic [N_W-1:0] acc_next;

  // One restoring step: the borrow of the trial subtraction decides the quotient bit.
  // The remainder never reaches 2*den, so a clear top bit of diff means rem_shift >= den.
  always_comb begin
    rem_shift = {rem_reg, acc_reg[N_W-1]};
    diff      = rem_shift - {1'b0, den_reg};
    ge        = ~diff[D_W];
    rem_next  = ge ? diff[D_W-1:0] : rem_shift[D_W-1:0];
    acc_next  = {acc_reg[N_W-2:0], ge};
  end

  // Load on start when idle, then iterate until the bit counter runs out; reset aborts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      rem_reg  <= '0;
      den_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (busy_reg) begin
      acc_reg <= acc_next;
      rem_reg <= rem_next;
      cnt_reg <= cnt_reg - CNT_BITS'(1);
      if (cnt_reg == CNT_BITS'(1)) begin
        busy_reg <= 1'b0;
      end
    end else if (start) begin
      acc_reg  <= num;
      rem_reg  <= '0;
      den_reg  <= den;
      cnt_reg  <= CNT_BITS'(N_W);
      busy_reg <= 1'b1;
    end
  end

  // done marks the final iteration; quo is the finished quotient in that cycle.
  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == CNT_BITS'(1));
  assign quo  = acc_next;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: synchronises pwm_in, measures high time and period between
// rising edges, divides for an integer duty percentage and flags stuck inputs.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT     = 200_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_pct,
  output logic [CNT_W-1:0]  high_cycles,
  output logic [CNT_W-1:0]  period_cycles,
  output logic              meas_valid,
  output logic              stuck_high,
  output logic              stuck_low,
  output logic              overrun
);

  localparam int               DIV_W      = div_w(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [DIV_W-1:0] DUTY_MAX_Q = DIV_W'(DUTY_MAX);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_d_reg;
  logic                   s;
  logic                   rise;

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] period_cnt_reg;
  logic [CNT_W-1:0] high_cnt_reg;
  logic [CNT_W-1:0] snap_high_reg;
  logic [CNT_W-1:0] snap_period_reg;

  logic             snap_take;
  logic             timeout_hit;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_num;
  logic [DIV_W-1:0] div_quo;
  logic [DUTY_W-1:0] duty_next;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
      s_d_reg  <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;

  // A rise closes a period only once armed; a rise in the timeout cycle still wins.
  assign snap_take   = (state_reg == ST_RUN) && rise;
  assign timeout_hit = (state_reg == ST_RUN) && !rise && (period_cnt_reg == TIMEOUT_C);
  assign div_start   = snap_take && !div_busy;
  assign div_num     = DIV_W'(high_cnt_reg) * DUTY_MAX_Q;

  // Measurement FSM: saturating period/high counters restarted on every rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rise) begin
            state_reg      <= ST_RUN;
            period_cnt_reg <= CNT_W'(1);
            high_cnt_reg   <= CNT_W'(1);
          end
        end
        default: begin
          if (rise) begin
            period_cnt_reg <= CNT_W'(1);
            high_cnt_reg   <= CNT_W'(1);
          end else if (timeout_hit) begin
            state_reg      <= ST_IDLE;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
          end else begin
            if (period_cnt_reg != CNT_MAX) begin
              period_cnt_reg <= period_cnt_reg + CNT_W'(1);
            end
            if (s && (high_cnt_reg != CNT_MAX)) begin
              high_cnt_reg <= high_cnt_reg + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Hold the accepted snapshot so it can be published alongside its quotient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_high_reg   <= '0;
      snap_period_reg <= '0;
    end else if (div_start) begin
      snap_high_reg   <= high_cnt_reg;
      snap_period_reg <= period_cnt_reg;
    end
  end

  pwm_div_restoring #(
    .N_W (DIV_W),
    .D_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (period_cnt_reg),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // high <= period keeps the quotient <= 100; the clamp only guards against surprises.
  assign duty_next = (div_quo > DUTY_MAX_Q) ? DUTY_W'(DUTY_MAX) : div_quo[DUTY_W-1:0];

  // Published outputs change only alongside a meas_valid pulse. The divider is
  // idle again in the cycle results appear, so a rise there is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_pct      <= '0;
      high_cycles   <= '0;
      period_cycles <= '0;
      meas_valid    <= 1'b0;
      stuck_high    <= 1'b0;
      stuck_low     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (div_done) begin
        duty_pct      <= duty_next;
        high_cycles   <= snap_high_reg;
        period_cycles <= snap_period_reg;
        meas_valid    <= 1'b1;
        stuck_high    <= 1'b0;
        stuck_low     <= 1'b0;
      end else if (timeout_hit) begin
        duty_pct      <= s ? DUTY_W'(DUTY_MAX) : '0;
        high_cycles   <= '0;
        period_cycles <= '0;
        meas_valid    <= 1'b1;
        stuck_high    <= s;
        stuck_low     <= ~s;
      end
      if (snap_take && div_busy) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: stimulus pushes expected measurements,
// a negedge monitor pops and compares them when meas_valid pulses.
module tb_pwm_duty_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 2000;
  localparam int DIV_W   = CNT_W + 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [7:0]       duty_pct;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] period_cycles;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;
  logic             overrun;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int prev_h = 0;
  int prev_p = 1;

  typedef struct {
    int duty;
    int high;
    int period;
    bit sh;
    bit sl;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .duty_pct      (duty_pct),
    .high_cycles   (high_cycles),
    .period_cycles (period_cycles),
    .meas_valid    (meas_valid),
    .stuck_high    (stuck_high),
    .stuck_low     (stuck_low),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void push_meas(input int h, input int p, input int at);
    exp_t e;
    e.duty = (h * 100) / p;
    if (e.duty > 100) e.duty = 100;
    e.high = h;
    e.period = p;
    e.sh = 1'b0;
    e.sl = 1'b0;
    e.at = at;
    sb.push_back(e);
  endfunction

  function automatic void push_stuck(input bit lvl, input int at);
    exp_t e;
    e.duty = lvl ? 100 : 0;
    e.high = 0;
    e.period = 0;
    e.sh = lvl;
    e.sl = !lvl;
    e.at = at;
    sb.push_back(e);
  endfunction

  // Monitor: every meas_valid pulse must match the oldest expectation, cycle included.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_meas_valid", longint'(meas_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        $display("meas at cycle %0d: duty=%0d high=%0d period=%0d sh=%0d sl=%0d",
                 cyc, duty_pct, high_cycles, period_cycles, stuck_high, stuck_low);
        chk("meas_cycle", cyc, mon_e.at);
        chk("duty_pct", longint'(duty_pct), mon_e.duty);
        chk("high_cycles", longint'(high_cycles), mon_e.high);
        chk("period_cycles", longint'(period_cycles), mon_e.period);
        chk("stuck_high", longint'(stuck_high), longint'(mon_e.sh));
        chk("stuck_low", longint'(stuck_low), longint'(mon_e.sl));
      end
    end
  end

  // One period starting with a rising edge; that rise optionally closes the previous period.
  task automatic wave(input int h, input int p, input bit close_prev);
    @(negedge clk);
    pwm_in = 1'b1;
    if (close_prev) push_meas(prev_h, prev_p, cyc + 3 + DIV_W);
    prev_h = h;
    prev_p = p;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h - 1) @(negedge clk);
  endtask

  // Close the previous period, then leave the input stuck at lvl until timeout.
  task automatic rise_hold(input bit lvl, input int h);
    @(negedge clk);
    pwm_in = 1'b1;
    push_meas(prev_h, prev_p, cyc + 3 + DIV_W);
    push_stuck(lvl, cyc + 3 + TIMEOUT);
    if (!lvl) begin
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_duty"}, longint'(duty_pct), 0);
    chk({tag, "_high"}, longint'(high_cycles), 0);
    chk({tag, "_period"}, longint'(period_cycles), 0);
    chk({tag, "_mv"}, longint'(meas_valid), 0);
    chk({tag, "_sh"}, longint'(stuck_high), 0);
    chk({tag, "_sl"}, longint'(stuck_low), 0);
    chk({tag, "_overrun"}, longint'(overrun), 0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 25% three times, then 1000/1001 (floor to 99), then a 50% period
    wave(250, 1000, 0);
    wave(250, 1000, 1);
    wave(250, 1000, 1);
    wave(1000, 1001, 1);
    wave(500, 1000, 1);

    // stuck low: one pulse at timeout, then nothing more
    rise_hold(0, 500);
    drain(TIMEOUT + 100);
    repeat (200) @(negedge clk);
    chk("t3_stuck_low_level", longint'(stuck_low), 1);
    chk("t3_duty_zero", longint'(duty_pct), 0);
    wave(500, 1000, 0);
    chk("t3_stuck_low_held", longint'(stuck_low), 1);

    // stuck high: the 50% result clears stuck_low, then timeout sets stuck_high
    rise_hold(1, 0);
    drain(TIMEOUT + 100);
    chk("t4_stuck_high_level", longint'(stuck_high), 1);
    chk("t4_duty_full", longint'(duty_pct), 100);
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    wave(300, 1000, 0);
    chk("t4_stuck_high_after_arm", longint'(stuck_high), 1);

    // short periods overrun the divider; published values stay at 300/1000
    wave(5, 10, 1);
    wave(5, 10, 0);
    wave(500, 1000, 0);
    chk("t5_overrun", longint'(overrun), 1);
    chk("t5_keep_high", longint'(high_cycles), 300);
    chk("t5_keep_period", longint'(period_cycles), 1000);
    chk("t5_keep_duty", longint'(duty_pct), 30);

    // period DIV_W+1 is the shortest period that is still accepted
    wave(16, 32, 1);
    wave(16, 32, 1);
    wave(16, 32, 1);

    // reset 10 cycles after a rise that started a divide
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    pwm_in = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("midreset");
    repeat (60) @(negedge clk);
    wave(333, 1000, 0);
    wave(100, 500, 1);
    @(negedge clk);
    pwm_in = 1'b1;
    push_meas(prev_h, prev_p, cyc + 3 + DIV_W);
    drain(200);
    chk("t6_overrun_clear", longint'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
